ternary_neuron_accum: RTL and testbench

//  Downstream consumer of the popcount22 approximate popcount stages. Each beat carries two
//  5-bit counts, pos_cnt (+1 weights) and neg_cnt (-1 weights), over one 22-input chunk.
//  The block sums (pos_cnt - neg_cnt) across a frame of up to NUM_BEATS beats, compares the
//  sum against two thresholds and emits one ternary activation per frame.

---
 rtl/tnn_pkg.sv | 18 +
 rtl/ternary_act.sv | 28 ++
 rtl/ternary_neuron_accum.sv | 167 ++++++++++++++++
 tb/tb_ternary_neuron_accum.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/tnn_pkg.sv
// Shared types for the ternary neuron accumulator: activation encoding, FSM states, count width.
package tnn_pkg;

  localparam int POPCNT_W = 5;

  typedef enum logic [1:0] {
    ACT_ZERO = 2'b00,
    ACT_POS  = 2'b01,
    ACT_NEG  = 2'b11
  } tern_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACC    = 2'b01,
    S_RESULT = 2'b10
  } state_t;

endpackage

// File: rtl/ternary_act.sv
// Combinational threshold compare mapping a signed frame sum to a ternary activation.
module ternary_act
  import tnn_pkg::*;
#(
  parameter int ACC_W  = 8,
  parameter int THR_HI = 4,
  parameter int THR_LO = -4
) (
  input  logic [ACC_W-1:0] acc_i,
  output tern_t            act_o
);

  localparam logic signed [ACC_W-1:0] HI_L = ACC_W'(THR_HI);
  localparam logic signed [ACC_W-1:0] LO_L = ACC_W'(THR_LO);

  // Upper threshold takes priority; THR_LO < THR_HI keeps the two ranges disjoint.
  always_comb begin
    act_o = ACT_ZERO;
    if ($signed(acc_i) >= HI_L) begin
      act_o = ACT_POS;
    end else if ($signed(acc_i) <= LO_L) begin
      act_o = ACT_NEG;
    end else begin
      act_o = ACT_ZERO;
    end
  end

endmodule

// File: rtl/ternary_neuron_accum.sv
// Frame accumulator of (pos_cnt - neg_cnt) with one ternary activation per frame.
// Optional feature: define TNA_SAT_EN for a saturating accumulator instead of two's-complement wrap.
module ternary_neuron_accum
  import tnn_pkg::*;
#(
  parameter int NUM_BEATS = 4,
  parameter int ACC_W     = 8,
  parameter int THR_HI    = 4,
  parameter int THR_LO    = -4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [POPCNT_W-1:0] pos_cnt_i,
  input  logic [POPCNT_W-1:0] neg_cnt_i,
  input  logic                in_last_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [1:0]          out_act_o,
  output logic [ACC_W-1:0]    out_acc_o,
  output logic                frame_err_o
);

  localparam int CNT_W = $clog2(NUM_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);
`ifdef TNA_SAT_EN
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (ACC_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-((1 << (ACC_W - 1)) - 1));
`endif

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  tern_t              out_act_q, out_act_d;
  logic [ACC_W-1:0]   out_acc_q, out_acc_d;
  logic               frame_err_q, frame_err_d;

  logic signed [POPCNT_W:0] diff_s;
  logic [ACC_W-1:0]         delta_s;
  logic [ACC_W-1:0]         base_s;
  logic signed [ACC_W:0]    wide_s;
  logic [ACC_W-1:0]         sum_s;
  tern_t                    sum_act_s;
  logic                     accept_s;
  logic                     close_s;
  logic                     consume_s;

  assign accept_s  = in_valid_i & in_ready_q;
  assign close_s   = in_last_i | (beat_cnt_q == LAST_CNT);
  assign consume_s = out_valid_q & out_ready_i;

  // Candidate running sum for the beat on the inputs; one guard bit catches overflow.
  always_comb begin
    diff_s  = $signed({1'b0, pos_cnt_i}) - $signed({1'b0, neg_cnt_i});
    delta_s = {{(ACC_W - POPCNT_W - 1){diff_s[POPCNT_W]}}, diff_s};
    if (state_q == S_IDLE) begin
      base_s = '0;
    end else begin
      base_s = acc_q;
    end
    wide_s = $signed({base_s[ACC_W-1], base_s}) + $signed({delta_s[ACC_W-1], delta_s});
`ifdef TNA_SAT_EN
    if (wide_s > SAT_MAX) begin
      sum_s = SAT_MAX[ACC_W-1:0];
    end else if (wide_s < SAT_MIN) begin
      sum_s = SAT_MIN[ACC_W-1:0];
    end else begin
      sum_s = wide_s[ACC_W-1:0];
    end
`else
    sum_s = wide_s[ACC_W-1:0];
`endif
  end

  ternary_act #(
    .ACC_W  (ACC_W),
    .THR_HI (THR_HI),
    .THR_LO (THR_LO)
  ) u_act (
    .acc_i (sum_s),
    .act_o (sum_act_s)
  );

  // Next-state logic; the closing beat loads the result registers on the same edge.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_act_d   = out_act_q;
    out_acc_d   = out_acc_q;
    frame_err_d = frame_err_q;
    case (state_q)
      S_IDLE, S_ACC: begin
        if (accept_s) begin
          acc_d      = sum_s;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (close_s) begin
            state_d     = S_RESULT;
            out_valid_d = 1'b1;
            out_acc_d   = sum_s;
            out_act_d   = sum_act_s;
            if (!in_last_i) begin
              frame_err_d = 1'b1;
            end else begin
              frame_err_d = frame_err_q;
            end
          end else begin
            state_d = S_ACC;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_RESULT: begin
        if (consume_s) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          beat_cnt_d  = '0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_RESULT;
        end
      end
      default: begin
        state_d     = S_IDLE;
        acc_d       = '0;
        beat_cnt_d  = '0;
        out_valid_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d != S_RESULT);
  end

  // State and output registers; in_ready stays low until the first edge after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      beat_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_act_q   <= ACT_ZERO;
      out_acc_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beat_cnt_q  <= beat_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_act_q   <= out_act_d;
      out_acc_q   <= out_acc_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_act_o   = out_act_q;
  assign out_acc_o   = out_acc_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_ternary_neuron_accum.sv
// Directed bench for ternary_neuron_accum: frame table plus hand-written handshake/reset sequences.
module tb_ternary_neuron_accum;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, in_last, out_valid, out_ready, frame_err;
  logic [4:0] pos, neg;
  logic [1:0] out_act;
  logic [7:0] out_acc;

  logic       b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_frame_err;
  logic [4:0] b_pos, b_neg;
  logic [1:0] b_out_act;
  logic [7:0] b_out_acc;

  int checks;
  int failures;

  ternary_neuron_accum #(.NUM_BEATS(4), .ACC_W(8), .THR_HI(4), .THR_LO(-4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .pos_cnt_i(pos), .neg_cnt_i(neg), .in_last_i(in_last), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_act_o(out_act), .out_acc_o(out_acc), .frame_err_o(frame_err)
  );

  ternary_neuron_accum #(.NUM_BEATS(8), .ACC_W(8), .THR_HI(4), .THR_LO(-4)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .pos_cnt_i(b_pos), .neg_cnt_i(b_neg), .in_last_i(b_in_last), .out_valid_o(b_out_valid),
    .out_ready_i(b_out_ready), .out_act_o(b_out_act), .out_acc_o(b_out_acc),
    .frame_err_o(b_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]      nbeats;
    logic [3:0][4:0] pos;
    logic [3:0][4:0] neg;
    logic [3:0]      last;
    logic [7:0]      exp_acc;
    logic [1:0]      exp_act;
    logic            exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic send_beat(input logic [4:0] p, input logic [4:0] n, input logic l);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1; pos = p; neg = n; in_last = l;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("beat_timeout", 8'd1, 8'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Checks the held result, then consumes it with a one-cycle out_ready pulse.
  task automatic check_result(input string name, input logic [7:0] e_acc,
                              input logic [1:0] e_act, input logic e_err);
    chk({name, "_valid"}, {7'd0, out_valid}, 8'd1);
    chk({name, "_acc"}, out_acc, e_acc);
    chk({name, "_act"}, {6'd0, out_act}, {6'd0, e_act});
    chk({name, "_err"}, {7'd0, frame_err}, {7'd0, e_err});
    chk({name, "_ready_low"}, {7'd0, in_ready}, 8'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, "_consumed"}, {7'd0, out_valid}, 8'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; pos = 5'd0; neg = 5'd0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_last = 1'b0; b_pos = 5'd0; b_neg = 5'd0; b_out_ready = 1'b0;

    vecs[0] = '{nbeats: 3'd3, pos: {5'd0, 5'd7, 5'd5, 5'd10}, neg: {5'd0, 5'd1, 5'd9, 5'd2},
                last: 4'b0100, exp_acc: 8'd10, exp_act: 2'b01, exp_err: 1'b0};
    vecs[1] = '{nbeats: 3'd1, pos: {15'd0, 5'd3}, neg: {15'd0, 5'd7},
                last: 4'b0001, exp_acc: 8'hFC, exp_act: 2'b11, exp_err: 1'b0};
    vecs[2] = '{nbeats: 3'd1, pos: {15'd0, 5'd2}, neg: {15'd0, 5'd2},
                last: 4'b0001, exp_acc: 8'd0, exp_act: 2'b00, exp_err: 1'b0};
    vecs[3] = '{nbeats: 3'd4, pos: {20'd0}, neg: {5'd31, 5'd31, 5'd31, 5'd31},
                last: 4'b1000, exp_acc: 8'h84, exp_act: 2'b11, exp_err: 1'b0};
    vecs[4] = '{nbeats: 3'd2, pos: {10'd0, 5'd2, 5'd1}, neg: {20'd0},
                last: 4'b0010, exp_acc: 8'd3, exp_act: 2'b00, exp_err: 1'b0};
    vecs[5] = '{nbeats: 3'd1, pos: {15'd0, 5'd4}, neg: {20'd0},
                last: 4'b0001, exp_acc: 8'd4, exp_act: 2'b01, exp_err: 1'b0};
    vecs[6] = '{nbeats: 3'd1, pos: {20'd0}, neg: {15'd0, 5'd3},
                last: 4'b0001, exp_acc: 8'hFD, exp_act: 2'b00, exp_err: 1'b0};

    #2;
    chk("rst_in_ready", {7'd0, in_ready}, 8'd0);
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_out_acc", out_acc, 8'd0);
    chk("rst_out_act", {6'd0, out_act}, 8'd0);
    chk("rst_frame_err", {7'd0, frame_err}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_ready", {7'd0, in_ready}, 8'd1);

    for (int i = 0; i < 7; i++) begin
      for (int b = 0; b < int'(vecs[i].nbeats); b++) begin
        send_beat(vecs[i].pos[b], vecs[i].neg[b], vecs[i].last[b]);
      end
      check_result($sformatf("vec%0d", i), vecs[i].exp_acc, vecs[i].exp_act, vecs[i].exp_err);
    end

    // Frame forced closed at NUM_BEATS without in_last.
    for (int b = 0; b < 4; b++) send_beat(5'd3, 5'd0, 1'b0);
    check_result("forced_close", 8'd12, 2'b01, 1'b1);

    // Back-pressure: result held while upstream already presents the next beat.
    send_beat(5'd1, 5'd0, 1'b0);
    send_beat(5'd8, 5'd0, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; pos = 5'd2; neg = 5'd2; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("hold_ready", {7'd0, in_ready}, 8'd0);
      chk("hold_valid", {7'd0, out_valid}, 8'd1);
      chk("hold_acc", out_acc, 8'd9);
      chk("hold_act", {6'd0, out_act}, 8'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_valid", {7'd0, out_valid}, 8'd0);
    chk("release_ready", {7'd0, in_ready}, 8'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    check_result("after_hold", 8'd0, 2'b00, 1'b1);

    // Wide frame on the NUM_BEATS=8 instance: 8 * 31 overflows 8 bits.
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      b_in_valid = 1'b1; b_pos = 5'd31; b_neg = 5'd0; b_in_last = (b == 7);
      @(posedge clk);
      #1;
    end
    b_in_valid = 1'b0; b_in_last = 1'b0;
    chk("wide_valid", {7'd0, b_out_valid}, 8'd1);
`ifdef TNA_SAT_EN
    chk("wide_acc", b_out_acc, 8'd127);
    chk("wide_act", {6'd0, b_out_act}, 8'd1);
`else
    chk("wide_acc", b_out_acc, 8'hF8);
    chk("wide_act", {6'd0, b_out_act}, 8'd3);
`endif
    chk("wide_err", {7'd0, b_frame_err}, 8'd0);

    // Reset mid-frame discards the partial sum and the sticky error.
    send_beat(5'd20, 5'd0, 1'b0);
    send_beat(5'd20, 5'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {7'd0, in_ready}, 8'd0);
    chk("midrst_valid", {7'd0, out_valid}, 8'd0);
    chk("midrst_acc", out_acc, 8'd0);
    chk("midrst_act", {6'd0, out_act}, 8'd0);
    chk("midrst_err", {7'd0, frame_err}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(5'd1, 5'd0, 1'b1);
    check_result("post_rst", 8'd1, 2'b00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
